bp_sacc_vdp_dispatch: RTL and testbench

- Upstream command sequencer for the vector dot-product streaming accelerator.
- Accepts one job descriptor per handshake: a_ptr, b_ptr, len, res_ptr. Issues the uncached CSR-write sequence over the CCE-IO command port, polls for completion, reads the 64-bit result back from the accelerator scratchpad, and returns it.
- Sits between a core-side job queue (or test harness) and the accelerator's io_cmd_i/io_resp_o ports.

---
 rtl/bp_sacc_vdp_pkg.sv | 87 ++++++++
 rtl/bp_sacc_vdp_dispatch_io_txn.sv | 83 ++++++++
 rtl/bp_sacc_vdp_dispatch.sv | 199 +++++++++++++++++++
 tb/tb_bp_sacc_vdp_dispatch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_sacc_vdp_pkg.sv
// Shared types and constants for the vector dot-product dispatcher.
// Holds the CCE mem message layout, CSR map, error codes and job descriptor.
package bp_sacc_vdp_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_inv_cfg     = 2'd1
    } bp_params_e;

    localparam int paddr_width_gp     = 40;
    localparam int cce_block_width_gp = 128;
    localparam int lce_id_width_gp    = 2;
    localparam int lce_assoc_gp       = 8;
    localparam int way_id_width_gp    = $clog2(lce_assoc_gp);

    localparam logic [63:0] csr_a_ptr_offset_gp   = 64'h000;
    localparam logic [63:0] csr_b_ptr_offset_gp   = 64'h040;
    localparam logic [63:0] csr_len_offset_gp     = 64'h080;
    localparam logic [63:0] csr_start_offset_gp   = 64'h0C0;
    localparam logic [63:0] csr_status_offset_gp  = 64'h100;
    localparam logic [63:0] csr_res_ptr_offset_gp = 64'h140;
    localparam logic [63:0] csr_res_len_offset_gp = 64'h180;
    localparam logic [63:0] csr_op_offset_gp      = 64'h200;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'h0,
        e_cce_mem_wr    = 4'h1,
        e_cce_mem_uc_rd = 4'h2,
        e_cce_mem_uc_wr = 4'h3
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'b000,
        e_mem_msg_size_2  = 3'b001,
        e_mem_msg_size_4  = 3'b010,
        e_mem_msg_size_8  = 3'b011,
        e_mem_msg_size_16 = 3'b100,
        e_mem_msg_size_32 = 3'b101,
        e_mem_msg_size_64 = 3'b110
    } bp_mem_msg_size_e;

    typedef enum logic [1:0] {
        e_sacc_err_ok      = 2'b00,
        e_sacc_err_len     = 2'b01,
        e_sacc_err_timeout = 2'b10
    } bp_sacc_err_e;

    typedef logic [paddr_width_gp-1:0] bp_paddr_t;

    typedef struct packed {
        logic [lce_id_width_gp-1:0] lce_id;
        logic [way_id_width_gp-1:0] way_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [cce_block_width_gp-1:0] data;
        bp_cce_mem_payload_s           payload;
        bp_mem_msg_size_e              size;
        bp_paddr_t                     addr;
        bp_cce_mem_cmd_type_e          msg_type;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

    typedef struct packed {
        logic [63:0] res_ptr;
        logic [63:0] len;
        logic [63:0] b_ptr;
        logic [63:0] a_ptr;
    } bp_sacc_job_s;

    function automatic int bp_cce_mem_msg_width(bp_params_e cfg);
        int w;
        case (cfg)
            e_bp_inv_cfg: w = $bits(bp_cce_mem_msg_s);
            default:      w = $bits(bp_cce_mem_msg_s);
        endcase
        return w;
    endfunction

    // Base + offset, truncated to the physical address width.
    function automatic bp_paddr_t bp_sacc_addr(logic [63:0] base,
                                               logic [63:0] off);
        return bp_paddr_t'(base + off);
    endfunction

endpackage

// File: rtl/bp_sacc_vdp_dispatch_io_txn.sv
// One uncached CCE-IO transaction: SEND until taken, WAIT for the reply.
// start_i is held by the caller for the whole transaction; done_o pulses.
module bp_sacc_io_txn
    import bp_sacc_vdp_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic                            wr_i,
    input  logic [paddr_width_gp-1:0]       addr_i,
    input  logic [63:0]                     wdata_i,
    output logic                            done_o,
    output logic [63:0]                     rdata_o,
    output logic [cce_mem_msg_width_gp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_yumi_i,
    input  logic [cce_mem_msg_width_gp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_ready_o
);

    typedef enum logic {
        e_tx_send = 1'b0,
        e_tx_wait = 1'b1
    } tx_state_e;

    tx_state_e       state_r, state_n;
    bp_cce_mem_msg_s cmd;
    bp_cce_mem_msg_s resp;
    logic            unused_resp;

    // Phase register: back to SEND on reset so nothing stays outstanding.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_tx_send;
        end else begin
            state_r <= state_n;
        end
    end

    // Handshake sequencing; a reply seen during SEND is not accepted.
    always_comb begin
        state_n         = state_r;
        io_cmd_v_o      = 1'b0;
        io_resp_ready_o = 1'b0;
        done_o          = 1'b0;
        unique case (state_r)
            e_tx_send: begin
                if (start_i) begin
                    io_cmd_v_o = 1'b1;
                    if (io_cmd_yumi_i) begin
                        state_n = e_tx_wait;
                    end
                end
            end
            e_tx_wait: begin
                io_resp_ready_o = 1'b1;
                if (io_resp_v_i) begin
                    done_o  = 1'b1;
                    state_n = e_tx_send;
                end
            end
        endcase
    end

    // Command image is a pure function of the held request inputs.
    always_comb begin
        cmd           = '0;
        cmd.msg_type  = wr_i ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        cmd.size      = e_mem_msg_size_8;
        cmd.addr      = addr_i;
        cmd.data[63:0] = wdata_i;
    end

    assign io_cmd_o = cmd;
    assign resp     = io_resp_i;
    assign rdata_o  = resp.data[63:0];

    assign unused_resp = ^{resp.data[cce_block_width_gp-1:64],
                           resp.payload, resp.size,
                           resp.addr, resp.msg_type};

endmodule

// File: rtl/bp_sacc_vdp_dispatch.sv
// Job sequencer for the dot-product accelerator: CSR writes, poll, readback.
// Drives a single bp_sacc_io_txn so exactly one command is ever in flight.
module bp_sacc_vdp_dispatch
    import bp_sacc_vdp_pkg::*;
#(
    parameter bp_params_e  bp_params_p     = e_bp_inv_cfg,
    parameter logic [63:0] csr_base_addr_p = 64'h0,
    parameter logic [63:0] spm_base_addr_p = 64'h0,
    parameter int          max_poll_p      = 1024,
    localparam int cce_mem_msg_width_lp = bp_cce_mem_msg_width(bp_params_p)
)
(
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [255:0]                    job_i,
    input  logic                            job_v_i,
    output logic                            job_ready_o,
    output logic [63:0]                     result_o,
    output logic [1:0]                      error_o,
    output logic                            result_v_o,
    input  logic                            result_yumi_i,
    output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_yumi_i,
    input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_ready_o
);

    localparam int poll_w_lp = $clog2(max_poll_p + 1);
    localparam logic [poll_w_lp-1:0] poll_max_lp = poll_w_lp'(max_poll_p);

    typedef enum logic [3:0] {
        e_idle     = 4'd0,
        e_wr_a     = 4'd1,
        e_wr_b     = 4'd2,
        e_wr_len   = 4'd3,
        e_wr_res   = 4'd4,
        e_wr_start = 4'd5,
        e_poll     = 4'd6,
        e_rd_res   = 4'd7,
        e_result   = 4'd8
    } state_e;

    state_e         state_r, state_n;
    bp_sacc_job_s   job_r, job_n, job_in;
    logic [63:0]    result_r, result_n;
    bp_sacc_err_e   error_r, error_n;
    logic [poll_w_lp-1:0] poll_cnt_r, poll_cnt_n, poll_cnt_inc;

    logic           bad_len;
    logic           txn_start;
    logic           txn_wr;
    bp_paddr_t      txn_addr;
    logic [63:0]    txn_wdata;
    logic           txn_done;
    logic [63:0]    txn_rdata;

    assign job_in       = job_i;
    assign bad_len      = (job_in.len == 64'd0) || (job_in.len > 64'd8);
    assign poll_cnt_inc = poll_cnt_r + poll_w_lp'(1);

    assign job_ready_o = (state_r == e_idle);
    assign result_v_o  = (state_r == e_result);
    assign result_o    = result_r;
    assign error_o     = error_r;

    // Sequencer state and job registers; reset drops any job in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_idle;
            job_r      <= '0;
            result_r   <= '0;
            error_r    <= e_sacc_err_ok;
            poll_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            job_r      <= job_n;
            result_r   <= result_n;
            error_r    <= error_n;
            poll_cnt_r <= poll_cnt_n;
        end
    end

    // Next state plus the request presented to the transaction unit.
    always_comb begin
        state_n    = state_r;
        job_n      = job_r;
        result_n   = result_r;
        error_n    = error_r;
        poll_cnt_n = poll_cnt_r;
        txn_start  = 1'b0;
        txn_wr     = 1'b1;
        txn_addr   = '0;
        txn_wdata  = '0;
        unique case (state_r)
            e_idle: begin
                if (job_v_i) begin
                    job_n = job_in;
                    if (bad_len) begin
                        state_n  = e_result;
                        result_n = '0;
                        error_n  = e_sacc_err_len;
                    end else begin
                        state_n = e_wr_a;
                    end
                end
            end
            e_wr_a: begin
                txn_start = 1'b1;
                txn_addr  = bp_sacc_addr(csr_base_addr_p,
                                         csr_a_ptr_offset_gp);
                txn_wdata = job_r.a_ptr;
                if (txn_done) state_n = e_wr_b;
            end
            e_wr_b: begin
                txn_start = 1'b1;
                txn_addr  = bp_sacc_addr(csr_base_addr_p,
                                         csr_b_ptr_offset_gp);
                txn_wdata = job_r.b_ptr;
                if (txn_done) state_n = e_wr_len;
            end
            e_wr_len: begin
                txn_start = 1'b1;
                txn_addr  = bp_sacc_addr(csr_base_addr_p,
                                         csr_len_offset_gp);
                txn_wdata = job_r.len;
                if (txn_done) state_n = e_wr_res;
            end
            e_wr_res: begin
                txn_start = 1'b1;
                txn_addr  = bp_sacc_addr(csr_base_addr_p,
                                         csr_res_ptr_offset_gp);
                txn_wdata = job_r.res_ptr;
                if (txn_done) state_n = e_wr_start;
            end
            e_wr_start: begin
                txn_start = 1'b1;
                txn_addr  = bp_sacc_addr(csr_base_addr_p,
                                         csr_start_offset_gp);
                txn_wdata = 64'd1;
                if (txn_done) state_n = e_poll;
            end
            e_poll: begin
                txn_start = 1'b1;
                txn_wr    = 1'b0;
                txn_addr  = bp_sacc_addr(csr_base_addr_p,
                                         csr_start_offset_gp);
                if (txn_done) begin
                    if (txn_rdata == 64'd0) begin
                        state_n = e_rd_res;
                    end else begin
                        poll_cnt_n = poll_cnt_inc;
                        if (poll_cnt_inc == poll_max_lp) begin
                            state_n  = e_result;
                            result_n = '0;
                            error_n  = e_sacc_err_timeout;
                        end
                    end
                end
            end
            e_rd_res: begin
                txn_start = 1'b1;
                txn_wr    = 1'b0;
                txn_addr  = bp_sacc_addr(spm_base_addr_p, job_r.res_ptr);
                if (txn_done) begin
                    state_n  = e_result;
                    result_n = txn_rdata;
                    error_n  = e_sacc_err_ok;
                end
            end
            e_result: begin
                if (result_yumi_i) begin
                    state_n    = e_idle;
                    poll_cnt_n = '0;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    bp_sacc_io_txn u_txn (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .start_i         (txn_start),
        .wr_i            (txn_wr),
        .addr_i          (txn_addr),
        .wdata_i         (txn_wdata),
        .done_o          (txn_done),
        .rdata_o         (txn_rdata),
        .io_cmd_o        (io_cmd_o),
        .io_cmd_v_o      (io_cmd_v_o),
        .io_cmd_yumi_i   (io_cmd_yumi_i),
        .io_resp_i       (io_resp_i),
        .io_resp_v_i     (io_resp_v_i),
        .io_resp_ready_o (io_resp_ready_o)
    );

endmodule

// File: tb/tb_bp_sacc_vdp_dispatch.sv
// Directed bench for bp_sacc_vdp_dispatch with a small accelerator model.
// Checks command order, backpressure, bad length, timeout, stall and reset.
module tb_bp_sacc_vdp_dispatch;
    import bp_sacc_vdp_pkg::*;

    localparam logic [63:0] CSR = 64'h2000_0000;
    localparam logic [63:0] SPM = 64'h3000_0000;
    localparam logic [39:0] START_A = 40'h2000_00C0;
    localparam int MW = $bits(bp_cce_mem_msg_s);

    logic          clk = 1'b0;
    logic          reset_i;
    logic [255:0]  job_i;
    logic          job_v_i;
    logic          job_ready_o;
    logic [63:0]   result_o;
    logic [1:0]    error_o;
    logic          result_v_o;
    logic          result_yumi_i;
    logic [MW-1:0] io_cmd_o;
    logic          io_cmd_v_o;
    logic          io_cmd_yumi_i;
    logic [MW-1:0] io_resp_i;
    logic          io_resp_v_i;
    logic          io_resp_ready_o;

    int n_checks = 0;
    int n_err = 0;

    int stall = 0;
    int resp_delay = 1;
    int done_after = 3;
    logic [63:0] spm_val = 64'd70;
    int n_cmd = 0;
    int polls_seen = 0;
    int cmdv_cycles = 0;
    int instab = 0;
    bp_cce_mem_msg_s log_msg [0:63];

    always #5 clk = ~clk;

    bp_sacc_vdp_dispatch #(
        .bp_params_p     (e_bp_inv_cfg),
        .csr_base_addr_p (CSR),
        .spm_base_addr_p (SPM),
        .max_poll_p      (4)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .job_i           (job_i),
        .job_v_i         (job_v_i),
        .job_ready_o     (job_ready_o),
        .result_o        (result_o),
        .error_o         (error_o),
        .result_v_o      (result_v_o),
        .result_yumi_i   (result_yumi_i),
        .io_cmd_o        (io_cmd_o),
        .io_cmd_v_o      (io_cmd_v_o),
        .io_cmd_yumi_i   (io_cmd_yumi_i),
        .io_resp_i       (io_resp_i),
        .io_resp_v_i     (io_resp_v_i),
        .io_resp_ready_o (io_resp_ready_o)
    );

    // Accelerator model: takes commands after 'stall' cycles, replies later.
    initial begin : model
        bp_cce_mem_msg_s c;
        bp_cce_mem_msg_s r;
        logic [MW-1:0] first;
        int wait_cnt;
        int timer;
        bit seen;
        seen = 1'b0;
        wait_cnt = 0;
        timer = 0;
        first = '0;
        r = '0;
        io_cmd_yumi_i = 1'b0;
        io_resp_v_i = 1'b0;
        io_resp_i = '0;
        forever begin
            @(negedge clk);
            io_cmd_yumi_i = 1'b0;
            io_resp_v_i = 1'b0;
            if (timer != 0) begin
                timer--;
                if (timer == 0) begin
                    io_resp_v_i = 1'b1;
                    io_resp_i = r;
                end
            end
            if (io_cmd_v_o) begin
                cmdv_cycles++;
                if (!seen) begin
                    seen = 1'b1;
                    first = io_cmd_o;
                    wait_cnt = 0;
                end else if (io_cmd_o !== first) begin
                    instab++;
                end
                if (wait_cnt >= stall) begin
                    c = bp_cce_mem_msg_s'(io_cmd_o);
                    io_cmd_yumi_i = 1'b1;
                    if (n_cmd < 64) log_msg[n_cmd] = c;
                    n_cmd++;
                    r = c;
                    r.data = {64'hDEAD_BEEF_CAFE_F00D, 64'h0};
                    if (c.msg_type == e_cce_mem_uc_rd) begin
                        if (c.addr == START_A) begin
                            polls_seen++;
                            r.data[63:0] = (done_after != 0 &&
                                            polls_seen >= done_after)
                                           ? 64'd0 : 64'd1;
                        end else begin
                            r.data[63:0] = spm_val;
                        end
                    end else if (c.addr == START_A) begin
                        polls_seen = 0;
                    end
                    timer = resp_delay;
                    seen = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_job(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] len, input logic [63:0] res);
        chk("ready_before_job", 64'(job_ready_o), 64'd1);
        job_i = {res, len, b, a};
        job_v_i = 1'b1;
        @(negedge clk);
        job_v_i = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int k;
        k = 0;
        while (!result_v_o && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_result_v"}, 64'(result_v_o), 64'd1);
    endtask

    task automatic consume();
        result_yumi_i = 1'b1;
        @(negedge clk);
        result_yumi_i = 1'b0;
    endtask

    // Expected trace of the reference job (a=1000 b=1040 len=4 res=1080).
    task automatic check_job_log(input string tag, input int b);
        logic [39:0] ea [0:4];
        logic [63:0] ed [0:4];
        ea = '{40'h2000_0000, 40'h2000_0040, 40'h2000_0080,
               40'h2000_0140, 40'h2000_00C0};
        ed = '{64'h1000, 64'h1040, 64'h4, 64'h1080, 64'h1};
        chk({tag, "_ncmd"}, 64'(n_cmd - b), 64'd9);
        chk({tag, "_size"}, 64'(log_msg[b].size), 64'(e_mem_msg_size_8));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_wr%0d_type", tag, i),
                64'(log_msg[b+i].msg_type), 64'(e_cce_mem_uc_wr));
            chk($sformatf("%s_wr%0d_addr", tag, i),
                64'(log_msg[b+i].addr), 64'(ea[i]));
            chk($sformatf("%s_wr%0d_data", tag, i),
                log_msg[b+i].data[63:0], ed[i]);
        end
        for (int i = 5; i < 8; i++) begin
            chk($sformatf("%s_poll%0d_type", tag, i - 5),
                64'(log_msg[b+i].msg_type), 64'(e_cce_mem_uc_rd));
            chk($sformatf("%s_poll%0d_addr", tag, i - 5),
                64'(log_msg[b+i].addr), 64'h2000_00C0);
        end
        chk({tag, "_rd_type"}, 64'(log_msg[b+8].msg_type),
            64'(e_cce_mem_uc_rd));
        chk({tag, "_rd_addr"}, 64'(log_msg[b+8].addr), 64'h3000_1080);
    endtask

    initial begin : main
        int base;
        int vcy;
        int k;
        reset_i = 1'b1;
        job_i = '0;
        job_v_i = 1'b0;
        result_yumi_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        chk("rst_job_ready", 64'(job_ready_o), 64'd1);
        chk("rst_result_v", 64'(result_v_o), 64'd0);
        chk("rst_cmd_v", 64'(io_cmd_v_o), 64'd0);
        chk("rst_resp_ready", 64'(io_resp_ready_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);

        base = n_cmd;
        send_job(64'h1000, 64'h1040, 64'd4, 64'h1080);
        chk("basic_busy", 64'(job_ready_o), 64'd0);
        wait_result("basic");
        check_job_log("basic", base);
        chk("basic_result", result_o, 64'd70);
        chk("basic_error", 64'(error_o), 64'd0);
        chk("basic_stable", 64'(instab), 64'd0);
        consume();
        chk("basic_idle", 64'(job_ready_o), 64'd1);

        base = n_cmd;
        vcy = cmdv_cycles;
        send_job(64'h1000, 64'h1040, 64'd0, 64'h1080);
        chk("len0_result_v", 64'(result_v_o), 64'd1);
        chk("len0_error", 64'(error_o), 64'd1);
        chk("len0_result", result_o, 64'd0);
        consume();
        send_job(64'h1000, 64'h1040, 64'd9, 64'h1080);
        chk("len9_result_v", 64'(result_v_o), 64'd1);
        chk("len9_error", 64'(error_o), 64'd1);
        consume();
        chk("badlen_no_cmd", 64'(n_cmd - base), 64'd0);
        chk("badlen_no_cmd_v", 64'(cmdv_cycles - vcy), 64'd0);

        stall = 5;
        base = n_cmd;
        vcy = cmdv_cycles;
        send_job(64'h1000, 64'h1040, 64'd4, 64'h1080);
        wait_result("bp");
        check_job_log("bp", base);
        chk("bp_result", result_o, 64'd70);
        chk("bp_error", 64'(error_o), 64'd0);
        chk("bp_stable", 64'(instab), 64'd0);
        chk("bp_cmd_v_cycles", 64'(cmdv_cycles - vcy), 64'd54);
        consume();
        stall = 0;

        done_after = 0;
        base = n_cmd;
        send_job(64'h1000, 64'h1040, 64'd4, 64'h1080);
        wait_result("tmo");
        chk("tmo_error", 64'(error_o), 64'd2);
        chk("tmo_result", result_o, 64'd0);
        chk("tmo_polls", 64'(polls_seen), 64'd4);
        chk("tmo_ncmd", 64'(n_cmd - base), 64'd9);
        consume();

        done_after = 3;
        base = n_cmd;
        send_job(64'h1000, 64'h1040, 64'd4, 64'h1080);
        wait_result("stall");
        check_job_log("stall", base);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall_v_%0d", i), 64'(result_v_o), 64'd1);
            chk($sformatf("stall_rdy_%0d", i), 64'(job_ready_o), 64'd0);
        end
        chk("stall_result", result_o, 64'd70);
        result_yumi_i = 1'b1;
        job_i = {64'h0, 64'h0, 64'h0, 64'h0};
        job_v_i = 1'b1;
        @(negedge clk);
        result_yumi_i = 1'b0;
        chk("stall_next_ready", 64'(job_ready_o), 64'd1);
        chk("stall_not_same_cycle", 64'(result_v_o), 64'd0);
        @(negedge clk);
        job_v_i = 1'b0;
        chk("stall_taken_v", 64'(result_v_o), 64'd1);
        chk("stall_taken_err", 64'(error_o), 64'd1);
        consume();

        done_after = 0;
        resp_delay = 6;
        base = n_cmd;
        send_job(64'h1000, 64'h1040, 64'd4, 64'h1080);
        k = 0;
        while (n_cmd < base + 6 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rst_poll_issued", 64'(n_cmd - base), 64'd6);
        chk("rst_in_wait", 64'(io_resp_ready_o), 64'd1);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        k = 0;
        while (!io_resp_v_i && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("late_resp_seen", 64'(io_resp_v_i), 64'd1);
        chk("late_resp_ready", 64'(io_resp_ready_o), 64'd0);
        chk("late_job_ready", 64'(job_ready_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_job_ready", 64'(job_ready_o), 64'd1);
        chk("post_rst_result_v", 64'(result_v_o), 64'd0);
        chk("post_rst_cmd_v", 64'(io_cmd_v_o), 64'd0);
        chk("post_rst_resp_ready", 64'(io_resp_ready_o), 64'd0);
        chk("post_rst_result", result_o, 64'd0);
        chk("post_rst_error", 64'(error_o), 64'd0);
        chk("post_rst_no_cmd", 64'(n_cmd - base), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
